pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register for the RISC-V pipeline.
- Replaces fixed, hand-written inter-stage registers (E->M and similar) with one generic block.
- Carries a control bundle and a data bundle with a valid/ready handshake, synchronous flush (bubble insertion) and an optional skid entry.
- Each stage boundary instantiates one copy with its own widths.

Parameters:
- CTRL_W, 8, width of control bundle (write enables, writeback select, load/store select); forced to zero whenever the stage holds no valid entry.
- DATA_W, 101, width of data bundle (alu result, store data, rd, pc+4, ...); not cleared by flush.
- SKID, 1, 0 = single entry with combinational ready path; 1 = two entries (main + skid) with registered in_ready.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries and of this cycle's input.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  stage output holds a live entry.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_ctrl  out  CTRL_W  control of head entry; all-zero when out_valid=0.
- out_data  out  DATA_W  data of head entry.
- count  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).

Behaviour:
- One clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset: out_valid=0, out_ctrl=0, out_data=0, count=0, skid entry empty. in_ready=1 during and after reset.
- Latency: an accepted entry appears on out_* at the next rising edge, for both SKID values. Full throughput: one transfer per cycle when out_ready=1.

SKID=0:
- in_ready = !out_valid || out_ready (combinational).
- Main register loads on accept.
- out_valid next = accept || (out_valid && !out_ready).
- Pop without accept: out_ctrl cleared to 0; out_data holds.

SKID=1:
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- Accept while main is empty, or while main is popping: entry goes to main.
- Accept while main is full and not popping: entry goes to skid.
- Pop with skid full: skid moves to main and skid empties.
- Pop, skid full and accept in the same cycle: cannot occur, because in_ready=0 whenever skid is full.
- Entry order is strictly FIFO.

Common rules:
- Flush has priority over every other event. Next cycle:
  - all entries invalid, out_ctrl=0, count=0;
  - the input offered that cycle is dropped even if in_ready=1;
  - out_data is not cleared.
- A simultaneous downstream pop in a flush cycle is still a valid transfer. Downstream sampled it before the edge.
- Stall (out_ready=0 with a full stage): out_ctrl and out_data are held bit-stable.
- out_ctrl is never non-zero while out_valid=0. This guarantees no spurious register-file or memory writes from bubbles.
- count tracks held entries exactly: +1 per accept, -1 per pop, both in the same cycle = unchanged, flush -> 0.
- Reset asserted mid-stream: all state clears immediately, without waiting for a clock edge. The first accept after rst_n deasserts behaves as from empty.
- Widths pass through unmodified; no arithmetic on data.

Decomposition:
- Shared package pipe_pkg holds:
  - per-boundary width constants (EM_CTRL_W, EM_DATA_W, MW_CTRL_W, MW_DATA_W);
  - packed struct typedefs for each boundary's control and data bundles, so instances connect by struct.
- One sub-module is natural: pipe_entry_reg, a single valid+ctrl+data register with load/clear. Instantiate it twice when SKID=1 (main, skid) and once when SKID=0.
- Skid steering and the count logic live in the top module.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, out_data=0, count=0. Release reset, apply one accept of ctrl=8'h05, data=A -> out_valid=1, out_ctrl=8'h05 at the next edge.
- Streaming: out_ready=1, push 16 back-to-back entries data=0..15 -> outputs 0..15 in order, one per cycle, 1-cycle latency, count stays 1.
- Backpressure (SKID=1): out_ready=0, push 3 entries (10, 11, 12):
  - 10 to main, 11 to skid, then in_ready=0 and count=2;
  - 12 is held by upstream;
  - raise out_ready -> 10, 11, 12 in order with no loss or duplication.
- Backpressure (SKID=0): out_ready=0 with stage full -> in_ready=0 in the same cycle. Raise out_ready and push -> pop and accept in the same cycle, count stays 1.
- Flush: stage holding 2 entries plus in_valid=1 (data 20), assert flush for one cycle:
  - next cycle out_valid=0, out_ctrl=0, count=0;
  - entry 20 never appears at the output;
  - in_ready=1.
- Async reset mid-stream: drop rst_n between clock edges while full -> outputs clear before the next clk edge. Assert invariant out_valid=0 => out_ctrl=0 on every cycle of all tests.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage boundaries.
// Holds per-boundary bundle widths and packed struct types, so each
// pipe_stage_reg instance can be wired up by struct.
package pipe_pkg;

  // Execute -> Memory boundary
  localparam int EM_CTRL_W = 8;
  localparam int EM_DATA_W = 101;

  // Memory -> Writeback boundary
  localparam int MW_CTRL_W = 6;
  localparam int MW_DATA_W = 101;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] wb_sel;
    logic [2:0] ls_size;
  } em_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } em_data_t;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] ls_size;
  } mw_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] load_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } mw_data_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry: valid flag plus control and data bundles.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_load              capture i_ctrl/i_data and mark the entry valid
//   i_clear             invalidate the entry and zero its control; data holds
//   i_ctrl, i_data      incoming bundles
//   o_valid, o_ctrl, o_data  held entry
// Clear wins over load; the control bundle is zero whenever the entry is invalid.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EM_CTRL_W,
  parameter int DATA_W = EM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and
// an optional skid entry.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kill held entries and this cycle's input
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data upstream bundles
//   out_valid/out_ready   downstream handshake; out_ctrl/out_data head entry
//   count                 number of held entries
// SKID=0: one entry, in_ready depends combinationally on out_ready.
// SKID=1: main + skid entry, in_ready comes straight from the skid flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EM_CTRL_W,
  parameter int DATA_W = EM_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  logic              w_accept;
  logic              w_pop;
  logic              w_from_skid;
  logic              w_main_load;
  logic              w_main_clear;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;

  assign in_ready = SKID ? !w_skid_valid : (!w_main_valid || out_ready);

  assign w_pop       = w_main_valid && out_ready;
  assign w_accept    = in_valid && in_ready && !flush;
  // A popping main refills from skid first; in_ready is low then, so no input competes.
  assign w_from_skid = w_skid_valid && w_pop;

  assign w_main_load  = !flush && (w_from_skid || (w_accept && (!w_main_valid || w_pop)));
  assign w_main_clear = flush || (w_pop && !w_main_load);

  assign w_main_ctrl_in = w_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_from_skid ? w_skid_data : in_data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic w_skid_load;
      logic w_skid_clear;

      // Main is full and holding: the accepted entry parks in skid.
      assign w_skid_load  = w_accept && w_main_valid && !w_pop;
      assign w_skid_clear = flush || w_from_skid;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
    end
  endgenerate

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_ctrl;
  assign out_data  = w_main_data;
  assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance side by side,
// each fed from its own upstream source and checked every cycle against a
// small FIFO model of the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = EM_CTRL_W;
  localparam int DW = EM_DATA_W;
  localparam int SRC_N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                flush;
  logic [1:0]          in_valid, in_ready, out_valid, out_ready;
  logic [1:0][CW-1:0]  in_ctrl, out_ctrl;
  logic [1:0][DW-1:0]  in_data, out_data;
  logic [1:0][1:0]     count;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
    .count(count[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
    .count(count[1])
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: FIFO contents per DUT (index 0 = head), plus last head data seen.
  logic [CW-1:0] m_ctrl [2][2];
  logic [DW-1:0] m_data [2][2];
  int            m_cnt  [2];
  logic [DW-1:0] m_last [2];

  // Upstream sources: entries offered in order until accepted.
  logic [CW-1:0] s_ctrl [2][SRC_N];
  logic [DW-1:0] s_data [2][SRC_N];
  int            s_rd   [2];
  int            s_wr   [2];

  task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int d);
    if (d == 1) return (m_cnt[d] < 2);
    return (m_cnt[d] == 0) || out_ready[d];
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_last[d] = '0;
      s_rd[d]   = s_wr[d];
    end
  endtask

  task automatic src_push(input int d, input logic [CW-1:0] c, input logic [DW-1:0] v);
    if (s_wr[d] < SRC_N) begin
      s_ctrl[d][s_wr[d]] = c;
      s_data[d][s_wr[d]] = v;
      s_wr[d]++;
    end
  endtask

  task automatic push_both(input logic [CW-1:0] c, input logic [DW-1:0] v);
    src_push(0, c, v);
    src_push(1, c, v);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic check_state(input int d);
    chk("in_ready",    d, 128'(in_ready[d]),  128'(exp_ready(d)));
    chk("out_valid",   d, 128'(out_valid[d]), 128'(m_cnt[d] > 0));
    chk("out_ctrl",    d, 128'(out_ctrl[d]),  (m_cnt[d] > 0) ? 128'(m_ctrl[d][0]) : 128'(0));
    chk("out_data",    d, 128'(out_data[d]),  128'(m_last[d]));
    chk("count",       d, 128'(count[d]),     128'(m_cnt[d]));
    chk("bubble_ctrl", d, 128'(!out_valid[d] && (out_ctrl[d] != '0)), 128'(0));
  endtask

  // One clock: drive source heads, check pre-edge state, then advance model.
  task automatic step();
    logic rdy [2];
    logic acc, pop;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = (s_rd[d] != s_wr[d]);
      in_ctrl[d]  = in_valid[d] ? s_ctrl[d][s_rd[d]] : '0;
      in_data[d]  = in_valid[d] ? s_data[d][s_rd[d]] : '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_state(d);
      rdy[d] = exp_ready(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc = in_valid[d] && rdy[d];
      pop = (m_cnt[d] > 0) && out_ready[d];
      if (flush) begin
        m_cnt[d] = 0;
        if (in_valid[d]) s_rd[d]++;
      end else begin
        if (pop) begin
          m_ctrl[d][0] = m_ctrl[d][1];
          m_data[d][0] = m_data[d][1];
          m_cnt[d]--;
        end
        if (acc) begin
          m_ctrl[d][m_cnt[d]] = in_ctrl[d];
          m_data[d][m_cnt[d]] = in_data[d];
          m_cnt[d]++;
          s_rd[d]++;
        end
      end
      if (m_cnt[d] > 0) m_last[d] = m_data[d][0];
    end
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_rd[d] = 0;
      s_wr[d] = 0;
    end
    reset_model();

    // Reset with a live-looking input pending.
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 2'b00;
    in_valid  = 2'b11;
    in_ctrl   = {8'hFF, 8'hFF};
    in_data   = {rand_data(), rand_data()};
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, 128'(out_valid[d]), 128'(0));
      chk("rst_out_ctrl",  d, 128'(out_ctrl[d]),  128'(0));
      chk("rst_out_data",  d, 128'(out_data[d]),  128'(0));
      chk("rst_count",     d, 128'(count[d]),     128'(0));
      chk("rst_in_ready",  d, 128'(in_ready[d]),  128'(1));
    end
    in_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // First accept after reset shows up one edge later.
    push_both(8'h05, DW'(128'hA));
    step();
    for (int d = 0; d < 2; d++) begin
      chk("first_valid", d, 128'(out_valid[d]), 128'(1));
      chk("first_ctrl",  d, 128'(out_ctrl[d]),  128'(8'h05));
      chk("first_data",  d, 128'(out_data[d]),  128'(8'hA));
    end
    out_ready = 2'b11;
    step();

    // Streaming 0..15 back to back.
    for (int i = 0; i < 16; i++) push_both(CW'(i + 1), DW'(i));
    repeat (18) step();

    // Backpressure: 10, 11, 12 with downstream stalled.
    out_ready = 2'b00;
    push_both(8'h11, DW'(10));
    push_both(8'h12, DW'(11));
    push_both(8'h13, DW'(12));
    repeat (4) step();
    chk("bp_count", 1, 128'(count[1]), 128'(2));
    chk("bp_ready", 1, 128'(in_ready[1]), 128'(0));
    chk("bp_count", 0, 128'(count[0]), 128'(1));
    chk("bp_ready", 0, 128'(in_ready[0]), 128'(0));
    out_ready = 2'b11;
    repeat (6) step();

    // Flush with entries held and data 20 offered; SKID=0 side would accept it.
    out_ready = 2'b00;
    push_both(8'h21, DW'(18));
    push_both(8'h22, DW'(19));
    push_both(8'h23, DW'(20));
    src_push(1, 8'h24, DW'(99));
    repeat (3) step();
    flush     = 1'b1;
    out_ready = 2'b01;
    step();
    flush     = 1'b0;
    out_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk("flush_valid", d, 128'(out_valid[d]), 128'(0));
      chk("flush_ctrl",  d, 128'(out_ctrl[d]),  128'(0));
      chk("flush_count", d, 128'(count[d]),     128'(0));
    end
    chk("flush_ready", 0, 128'(in_ready[0]), 128'(1));
    repeat (2) step();
    out_ready = 2'b11;
    repeat (4) step();

    // Randomized traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ((s_rd[d] == s_wr[d]) && ($urandom_range(0, 3) != 0))
          src_push(d, CW'($urandom_range(0, 255)), rand_data());
        out_ready[d] = ($urandom_range(0, 2) != 0);
      end
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush     = 1'b0;
    out_ready = 2'b11;
    repeat (5) step();

    // Asynchronous reset while full.
    out_ready = 2'b00;
    push_both(8'h51, DW'(50));
    push_both(8'h52, DW'(51));
    push_both(8'h53, DW'(52));
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_valid", d, 128'(out_valid[d]), 128'(0));
      chk("arst_ctrl",  d, 128'(out_ctrl[d]),  128'(0));
      chk("arst_data",  d, 128'(out_data[d]),  128'(0));
      chk("arst_count", d, 128'(count[d]),     128'(0));
      chk("arst_ready", d, 128'(in_ready[d]),  128'(1));
    end
    reset_model();
    in_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 2'b11;
    push_both(8'h05, DW'(60));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
